ballot_session_ctrl: RTL

//  Sequencing controller in front of the 4-candidate vote tally datapath.
//  Per ballot: presiding officer arms one ballot; the block synchronises and debounces the raw buttons.
//  It rejects multi-presses and commits exactly one vote as a one-cycle strobe to the tally.
//  It then locks until the buttons are released and the next ballot is issued.

---
 rtl/ballot_session_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ballot_session_ctrl.sv
// Ballot session controller sitting in front of the 4-candidate tally.
// Synchronises the raw candidate buttons, debounces a single press,
// rejects multi-presses, commits exactly one vote per issued ballot and
// locks until the buttons are released. mode=1 freezes voting.
module ballot_session_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             ballot_en,
  input  logic [3:0]       button,
  output logic             vote_valid,
  output logic [1:0]       vote_cand,
  output logic             ready,
  output logic             reject,
  output logic             timeout,
  output logic [CNT_W-1:0] ballots_cast
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_DEBOUNCE = 3'd2,
    S_COMMIT   = 3'd3,
    S_WAIT_REL = 3'd4,
    S_REJ_WAIT = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       b_s_q, b_s_d;
  logic [3:0]       latch_q, latch_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             vote_valid_q, vote_valid_d;
  logic [1:0]       vote_cand_q, vote_cand_d;
  logic             ready_q, ready_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cast_q, cast_d;

  logic             b_onehot;
  logic             b_multi;
  logic             db_done;
  logic             tmo_hit;

  // True when exactly one button bit is set.
  function automatic logic is_onehot(input logic [3:0] b);
    return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
  endfunction

  // Candidate index of a one-hot button pattern.
  function automatic logic [1:0] onehot_idx(input logic [3:0] b);
    logic [1:0] idx;
    case (b)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Decode helpers on the synchronised button vector.
  always_comb begin
    b_onehot = is_onehot(b_s_q);
    b_multi  = (b_s_q != 4'd0) && !b_onehot;
    db_done  = (state_q == S_DEBOUNCE) && (b_s_q == latch_q) && (db_cnt_q == DB_LAST);
    tmo_hit  = (tmo_cnt_q == TMO_LAST);
  end

  // Next-state and registered-output computation for the ballot FSM.
  always_comb begin
    state_d      = state_q;
    sync1_d      = button;
    b_s_d        = sync1_q;
    latch_d      = latch_q;
    db_cnt_d     = db_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    vote_valid_d = 1'b0;
    vote_cand_d  = 2'd0;
    reject_d     = 1'b0;
    timeout_d    = 1'b0;
    cast_d       = cast_q;

    case (state_q)
      S_IDLE: begin
        if (ballot_en && !mode) begin
          state_d   = S_ARMED;
          tmo_cnt_d = '0;
          db_cnt_d  = '0;
        end
      end

      // The vote was already strobed on entry; COMMIT always completes.
      S_COMMIT: begin
        state_d = S_WAIT_REL;
      end

      // Held buttons keep the block locked; no second vote possible.
      S_WAIT_REL: begin
        if (b_s_q == 4'd0) begin
          state_d = S_IDLE;
        end
      end

      S_ARMED, S_DEBOUNCE, S_REJ_WAIT: begin
        // Priority: display mode cancels, then a completed debounce
        // beats an expiring timer, then the timer, then normal progress.
        if (mode) begin
          state_d  = S_IDLE;
          db_cnt_d = '0;
        end else if (db_done) begin
          state_d      = S_COMMIT;
          vote_valid_d = 1'b1;
          vote_cand_d  = onehot_idx(latch_q);
          cast_d       = sat_inc(cast_q);
          db_cnt_d     = '0;
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          db_cnt_d  = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          case (state_q)
            S_ARMED: begin
              if (b_onehot) begin
                state_d  = S_DEBOUNCE;
                latch_d  = b_s_q;
                db_cnt_d = DB_W'(1);
              end else if (b_multi) begin
                state_d  = S_REJ_WAIT;
                reject_d = 1'b1;
              end
            end
            S_DEBOUNCE: begin
              if (b_s_q == latch_q) begin
                db_cnt_d = db_cnt_q + DB_W'(1);
              end else if (b_multi) begin
                state_d  = S_REJ_WAIT;
                reject_d = 1'b1;
                db_cnt_d = '0;
              end else begin
                state_d  = S_ARMED;
                db_cnt_d = '0;
              end
            end
            default: begin
              // Rejected ballot stays open until every button is released.
              if (b_s_q == 4'd0) begin
                state_d = S_ARMED;
              end
            end
          endcase
        end
      end

      default: begin
        state_d  = S_IDLE;
        db_cnt_d = '0;
      end
    endcase

    ready_d = (state_d == S_ARMED) || (state_d == S_DEBOUNCE) || (state_d == S_REJ_WAIT);
  end

  // State, synchroniser and output registers; reset clears everything at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 4'd0;
      b_s_q        <= 4'd0;
      latch_q      <= 4'd0;
      db_cnt_q     <= '0;
      tmo_cnt_q    <= '0;
      vote_valid_q <= 1'b0;
      vote_cand_q  <= 2'd0;
      ready_q      <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      cast_q       <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      b_s_q        <= b_s_d;
      latch_q      <= latch_d;
      db_cnt_q     <= db_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      vote_valid_q <= vote_valid_d;
      vote_cand_q  <= vote_cand_d;
      ready_q      <= ready_d;
      reject_q     <= reject_d;
      timeout_q    <= timeout_d;
      cast_q       <= cast_d;
    end
  end

  assign vote_valid   = vote_valid_q;
  assign vote_cand    = vote_cand_q;
  assign ready        = ready_q;
  assign reject       = reject_q;
  assign timeout      = timeout_q;
  assign ballots_cast = cast_q;

endmodule
